tx_gearbox: RTL and testbench

- TX-direction 66b/64b gearbox. It is the transmit counterpart of the RX block-sync gearbox.
- Accepts 32-bit payload words plus a 2-bit sync header from the scrambler. Packs them into 66-bit blocks: {word1, word0, hdr}, block bit 0 = hdr[0].
- Emits a continuous 32-bit stream to the transceiver, LSB first on the wire.
- Rate mismatch (66 bits per 64 payload bits) is absorbed by a 33-cycle sequence. In each sequence, one cycle deasserts input ready.

---
 rtl/tx_gearbox.sv | 106 ++++++++++
 tb/tb_tx_gearbox.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tx_gearbox.sv
// tx_gearbox: transmit-side 66b/64b gearbox.
// Packs {word1, word0, hdr} into 66-bit blocks and emits a continuous 32-bit
// stream, LSB first. A 33-cycle sequence absorbs the rate mismatch. The last
// cycle of each sequence takes no input and flushes the 32-bit residual.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_tx_data            payload word from the scrambler
//   i_tx_sync_hdr        sync header, used only on the first word of a block
//   i_tx_data_valid      input word valid
//   o_tx_ready           a word is accepted this cycle when high
//   o_tx_data            gearboxed word, bit 0 goes on the wire first
//   o_tx_data_valid      o_tx_data holds a new word
//   o_hdr_err            pulse: an accepted header was 2'b00 or 2'b11
module tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2,
  parameter int SEQ_LEN    = 33
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [HDR_WIDTH-1:0]  i_tx_sync_hdr,
  input  logic                  i_tx_data_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_data_valid,
  output logic                  o_hdr_err
);
  localparam logic [5:0] LAST = 6'(SEQ_LEN - 1);

  typedef enum logic {FIRST, SECOND} phase_t;

  logic [5:0]              seq_cntr_q, seq_cntr_d;
  logic [DATA_WIDTH-1:0]   resid_q, resid_d;
  logic [5:0]              rcnt_q, rcnt_d;
  phase_t                  phase_q, phase_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    vld_q, vld_d;
  logic                    err_q, err_d;

  logic                    at_end, accept;
  logic [2*DATA_WIDTH-1:0] app, comb;

  assign o_tx_ready      = (seq_cntr_q != LAST);
  assign o_tx_data       = data_q;
  assign o_tx_data_valid = vld_q;
  assign o_hdr_err       = err_q;

  always_comb begin
    at_end = (seq_cntr_q == LAST);
    accept = o_tx_ready & i_tx_data_valid;
    // First word carries the header below the payload; second word is bare.
    if (phase_q == FIRST)
      app = {{(DATA_WIDTH-HDR_WIDTH){1'b0}}, i_tx_data, i_tx_sync_hdr};
    else
      app = {{DATA_WIDTH{1'b0}}, i_tx_data};
    // Residual never exceeds 32 bits, so appended bits always fit in 64.
    comb = (app << rcnt_q) | {{DATA_WIDTH{1'b0}}, resid_q};

    seq_cntr_d = seq_cntr_q;
    resid_d    = resid_q;
    rcnt_d     = rcnt_q;
    phase_d    = phase_q;
    data_d     = data_q;
    vld_d      = 1'b0;
    err_d      = 1'b0;

    if (at_end) begin
      // Flush cycle: the residual is exactly one full word.
      data_d     = resid_q;
      resid_d    = '0;
      rcnt_d     = '0;
      seq_cntr_d = '0;
      vld_d      = 1'b1;
    end else if (accept) begin
      data_d     = comb[DATA_WIDTH-1:0];
      resid_d    = comb[2*DATA_WIDTH-1:DATA_WIDTH];
      rcnt_d     = rcnt_q + ((phase_q == FIRST) ? 6'(HDR_WIDTH) : 6'd0);
      seq_cntr_d = seq_cntr_q + 6'd1;
      phase_d    = (phase_q == FIRST) ? SECOND : FIRST;
      vld_d      = 1'b1;
      err_d      = (phase_q == FIRST) &&
                   (i_tx_sync_hdr[0] == i_tx_sync_hdr[HDR_WIDTH-1]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seq_cntr_q <= '0;
      resid_q    <= '0;
      rcnt_q     <= '0;
      phase_q    <= FIRST;
      data_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      seq_cntr_q <= seq_cntr_d;
      resid_q    <= resid_d;
      rcnt_q     <= rcnt_d;
      phase_q    <= phase_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox. The reference model is a plain bit stream: every
// accepted word appends its bits (header first on block starts), and each
// emitted output word must be the next 32 bits of that stream.
module tb_tx_gearbox;
  logic        clk = 1'b1;
  logic        i_reset = 1'b1;
  logic [31:0] i_tx_data = '0;
  logic [1:0]  i_tx_sync_hdr = '0;
  logic        i_tx_data_valid = 1'b0;
  logic        o_tx_ready;
  logic [31:0] o_tx_data;
  logic        o_tx_data_valid;
  logic        o_hdr_err;

  always #5 clk = ~clk;

  tx_gearbox dut (
    .i_clk(clk), .i_reset(i_reset), .i_tx_data(i_tx_data),
    .i_tx_sync_hdr(i_tx_sync_hdr), .i_tx_data_valid(i_tx_data_valid),
    .o_tx_ready(o_tx_ready), .o_tx_data(o_tx_data),
    .o_tx_data_valid(o_tx_data_valid), .o_hdr_err(o_hdr_err)
  );

  typedef struct packed { logic vld; logic err; logic rst; } exp_t;

  exp_t        eq[$];
  bit          bq[$];
  int          checks = 0;
  int          failures = 0;
  int          cnt = 0;        // words accepted in current sequence
  bit          first_step = 1'b1;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One input cycle, driven at the negedge before the sampling edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] d,
                      input logic [1:0] h);
    exp_t e;
    @(negedge clk);
    if (!first_step) chk("ready", {63'd0, o_tx_ready}, {63'd0, cnt != 32});
    first_step = 1'b0;
    i_reset = rst; i_tx_data_valid = v; i_tx_data = d; i_tx_sync_hdr = h;
    e = '0;
    if (rst) begin
      e.rst = 1'b1; bq.delete(); cnt = 0;
    end else if (cnt == 32) begin
      e.vld = 1'b1; cnt = 0;
    end else if (v) begin
      e.vld = 1'b1;
      if (cnt % 2 == 0) begin
        bq.push_back(h[0]); bq.push_back(h[1]);
        e.err = (h == 2'b00) || (h == 2'b11);
      end
      for (int i = 0; i < 32; i++) bq.push_back(d[i]);
      cnt++;
    end
    eq.push_back(e);
  endtask

  // Monitor: one expectation per clock edge.
  initial begin
    exp_t        e;
    logic [31:0] w;
    forever begin
      @(posedge clk); #1;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("valid", {63'd0, o_tx_data_valid}, {63'd0, e.vld});
        if (e.rst) begin
          chk("rst_data", {32'd0, o_tx_data}, 64'd0);
          chk("rst_err", {63'd0, o_hdr_err}, 64'd0);
        end else if (e.vld) begin
          w = '0;
          if (bq.size() < 32) begin
            checks++; failures++;
            $display("FAIL underrun actual=%0d expected=32", bq.size());
          end else
            for (int i = 0; i < 32; i++) w[i] = bq.pop_front();
          chk("data", {32'd0, o_tx_data}, {32'd0, w});
          chk("hdr_err", {63'd0, o_hdr_err}, {63'd0, e.err});
        end else begin
          chk("hold", {32'd0, o_tx_data}, {32'd0, last_data});
          chk("err_idle", {63'd0, o_hdr_err}, 64'd0);
        end
        last_data = o_tx_data;
      end
    end
  end

  initial begin
    // Reset and first block
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 32'hAAAAAAAA, 2'b01);
    @(posedge clk); #2;
    chk("blk_w0", {32'd0, o_tx_data}, {32'd0, 32'hAAAAAAA9});
    step(0, 1, 32'h55555555, 2'b10);
    @(posedge clk); #2;
    chk("blk_w1", {32'd0, o_tx_data}, {32'd0, 32'h55555556});

    // Full sequence of incrementing words, then one more
    step(1, 0, 0, 0);
    for (int i = 0; i < 34; i++) step(0, 1, (i < 32) ? i : (i - 1), 2'b10);

    // Stall at seq_cntr 9
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, $urandom, 2'b01);
    for (int i = 0; i < 3; i++) step(0, 0, $urandom, 2'b01);
    for (int i = 0; i < 30; i++) step(0, 1, $urandom, 2'b10);

    // Reset mid-sequence at seq_cntr 17, then a fresh FIRST word
    step(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, $urandom, 2'b10);
    step(1, 0, 0, 0);
    step(0, 1, 32'h12345678, 2'b01);
    @(posedge clk); #2;
    chk("post_rst_hdr", {62'd0, o_tx_data[1:0]}, 64'd1);

    // Bad header on a FIRST word
    step(0, 1, 32'hDEADBEEF, 2'b10);
    step(0, 1, 32'hCAFEF00D, 2'b11);
    @(posedge clk); #2;
    chk("hdr_err_pulse", {63'd0, o_hdr_err}, 64'd1);
    step(0, 1, 32'h0BADF00D, 2'b00);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) step(1, 0, 0, 0);
      else step(0, ($urandom_range(0, 9) < 8), $urandom, 2'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    @(posedge clk); #3;
    chk("drain", {32'd0, 32'(eq.size())}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
